regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32 x 64-bit register file between two writeback requesters: port 0 is ALU writeback and port 1 is memory-load writeback.
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains one slot per cycle into registered rf_write/rf_address/rf_data outputs, which connect directly to the register file's write, address and data_in inputs.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_write_slot.sv | 48 ++++
 rtl/regfile_write_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and slot state encoding for the register-file write arbiter.
package regfile_pkg;
    localparam int REG_COUNT  = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int ZERO_REG   = 31;
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/regfile_write_slot.sv
// regfile_write_slot: one-entry holding slot with valid/ready capture and grant drain.
module regfile_write_slot
    import regfile_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int DW = DATA_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          valid_i,
    input  logic          grant_i,
    input  logic [AW-1:0] address_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          full_o,
    output logic [AW-1:0] address_o,
    output logic [DW-1:0] data_o
);
    slot_state_e   state_q, state_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] data_q, data_d;
    logic          accept;

    // grant_i only ever arrives while full, so this frees the slot for a same-edge refill
    assign ready_o   = (state_q == SLOT_EMPTY) || grant_i;
    assign accept    = valid_i && ready_o;
    assign full_o    = (state_q == SLOT_FULL);
    assign address_o = address_q;
    assign data_o    = data_q;

    always_comb begin
        state_d   = accept ? SLOT_FULL : grant_i ? SLOT_EMPTY : state_q;
        address_d = accept ? address_i : address_q;
        data_d    = accept ? data_i : data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= SLOT_EMPTY;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            data_q    <= data_d;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port between ALU and load writeback.
// Define REGFILE_ARB_STATS_EN to add saturating per-port grant counters.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_address,
    output logic [DATA_WIDTH-1:0] rf_data,
    output logic                  idle
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]           grant_count0,
    output logic [15:0]           grant_count1
`endif
);
    import regfile_pkg::*;

    logic                  full0, full1, grant0, grant1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] data0, data1;
    logic                  last_grant_q, last_grant_d;
    logic                  rf_write_q, rf_write_d;
    logic [ADDR_WIDTH-1:0] rf_address_q, rf_address_d;
    logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;

    regfile_write_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot0 (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (req0_valid),
        .grant_i   (grant0),
        .address_i (req0_address),
        .data_i    (req0_data),
        .ready_o   (req0_ready),
        .full_o    (full0),
        .address_o (addr0),
        .data_o    (data0)
    );

    regfile_write_slot #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_slot1 (
        .clock     (clock),
        .reset     (reset),
        .valid_i   (req1_valid),
        .grant_i   (grant1),
        .address_i (req1_address),
        .data_i    (req1_data),
        .ready_o   (req1_ready),
        .full_o    (full1),
        .address_o (addr1),
        .data_o    (data1)
    );

    // last_grant_q names the port served most recently; a tie goes to the other one
    always_comb begin
        grant0       = full0 && (!full1 || last_grant_q);
        grant1       = full1 && (!full0 || !last_grant_q);
        last_grant_d = grant1 ? 1'b1 : grant0 ? 1'b0 : last_grant_q;
        rf_address_d = grant0 ? addr0 : grant1 ? addr1 : rf_address_q;
        rf_data_d    = grant0 ? data0 : grant1 ? data1 : rf_data_q;
        rf_write_d   = (grant0 || grant1) && (rf_address_d != ADDR_WIDTH'(ZERO_REG));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            rf_write_q   <= 1'b0;
            rf_address_q <= '0;
            rf_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_write_q   <= rf_write_d;
            rf_address_q <= rf_address_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign rf_write   = rf_write_q;
    assign rf_address = rf_address_q;
    assign rf_data    = rf_data_q;
    assign idle       = !full0 && !full1 && !rf_write_q;

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant_count0_q, grant_count1_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_count0_q <= '0;
            grant_count1_q <= '0;
        end else begin
            if (grant0 && grant_count0_q != 16'hFFFF) grant_count0_q <= grant_count0_q + 16'd1;
            if (grant1 && grant_count1_q != 16'hFFFF) grant_count1_q <= grant_count1_q + 16'd1;
        end
    end

    assign grant_count0 = grant_count0_q;
    assign grant_count1 = grant_count1_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench for the register-file write arbiter.
module tb_regfile_write_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_address, req1_address, rf_address;
    logic [63:0] req0_data, req1_data, rf_data;
    logic        rf_write, idle;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant_count0, grant_count1;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [63:0] d;
    } wr_t;
    wr_t exp_q[$];

    logic [63:0] rf_mem [32];

    always #5 clock = ~clock;

    // stand-in for the external register file fed by the rf_* outputs
    always @(posedge clock) if (rf_write) rf_mem[rf_address] <= rf_data;

    regfile_write_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_address (req0_address),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_address (req1_address),
        .req1_data    (req1_data),
        .rf_write     (rf_write),
        .rf_address   (rf_address),
        .rf_data      (rf_data),
        .idle         (idle)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .grant_count0 (grant_count0),
        .grant_count1 (grant_count1)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        wr_t e;
        reset = 1'b0;
        req0_valid = 1'b1; req0_address = 5'd7; req0_data = 64'h77;
        req1_valid = 1'b0; req1_address = 5'd0; req1_data = 64'h0;
        tick();
        tick();
        total++; if (rf_write !== 1'b0) $display("FAIL reset_rf_write got=%b exp=0", rf_write); else passed++;
        total++; if (rf_address !== 5'd0) $display("FAIL reset_rf_address got=%0d exp=0", rf_address); else passed++;
        total++; if (rf_data !== 64'd0) $display("FAIL reset_rf_data got=%h exp=0", rf_data); else passed++;
        total++; if (req0_ready !== 1'b1) $display("FAIL reset_req0_ready got=%b exp=1", req0_ready); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else passed++;
        reset = 1'b1;
        req0_valid = 1'b0;
        tick();
        total++; if (idle !== 1'b1) $display("FAIL reset_no_capture idle got=%b exp=1", idle); else passed++;
        tick();
        total++; if (rf_write !== 1'b0) $display("FAIL reset_no_write got=%b exp=0", rf_write); else passed++;
        e = '0;
    endtask

    task automatic test_single();
        wr_t e;
        req0_address = 5'd5; req0_data = 64'hDEADBEEF_00000001; req0_valid = 1'b1;
        total++; if (req0_ready !== 1'b1) $display("FAIL single_ready got=%b exp=1", req0_ready); else passed++;
        exp_q.push_back({5'd5, 64'hDEADBEEF_00000001});
        tick();
        req0_valid = 1'b0;
        total++; if (rf_write !== 1'b0) $display("FAIL single_early_write got=%b exp=0", rf_write); else passed++;
        total++; if (idle !== 1'b0) $display("FAIL single_busy got=%b exp=0", idle); else passed++;
        tick();
        total++;
        if (rf_write !== 1'b1 || exp_q.size() == 0) $display("FAIL single_write rf_write got=%b exp=1 pending=%0d", rf_write, exp_q.size());
        else begin
            e = exp_q.pop_front();
            if ({rf_address, rf_data} !== e) $display("FAIL single_write got addr=%0d data=%h exp addr=%0d data=%h", rf_address, rf_data, e.a, e.d);
            else passed++;
        end
        total++; if (req0_ready !== 1'b1) $display("FAIL single_ready_after got=%b exp=1", req0_ready); else passed++;
        tick();
        total++; if (rf_mem[5] !== 64'hDEADBEEF_00000001) $display("FAIL single_commit got=%h exp=deadbeef00000001", rf_mem[5]); else passed++;
        total++; if (rf_write !== 1'b0) $display("FAIL single_write_drop got=%b exp=0", rf_write); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL single_idle got=%b exp=1", idle); else passed++;
    endtask

    task automatic test_contention();
        wr_t e;
        int  i0 = 0;
        int  i1 = 0;
        int  first = -1;
        int  last = -1;
        logic hs0, hs1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({5'(1 + i), 64'hA00000 + 64'(1 + i)});
            exp_q.push_back({5'(11 + i), 64'hB00000 + 64'(11 + i)});
        end
        for (int c = 0; c < 20; c++) begin
            req0_valid = (i0 < 3); req0_address = 5'(1 + i0); req0_data = 64'hA00000 + 64'(1 + i0);
            req1_valid = (i1 < 3); req1_address = 5'(11 + i1); req1_data = 64'hB00000 + 64'(11 + i1);
            if (i0 < 3 || i1 < 3) begin
                total++;
                if ((req0_ready | req1_ready) !== 1'b1) $display("FAIL contention_ready_stall cycle=%0d got r0=%b r1=%b exp one ready", c, req0_ready, req1_ready);
                else passed++;
            end
            hs0 = req0_valid & req0_ready;
            hs1 = req1_valid & req1_ready;
            tick();
            if (hs0) i0++;
            if (hs1) i1++;
            if (rf_write === 1'b1) begin
                total++;
                if (exp_q.size() == 0) $display("FAIL contention_extra_write got addr=%0d exp none", rf_address);
                else begin
                    e = exp_q.pop_front();
                    if ({rf_address, rf_data} !== e) $display("FAIL contention_order got addr=%0d data=%h exp addr=%0d data=%h", rf_address, rf_data, e.a, e.d);
                    else passed++;
                end
                if (first < 0) first = c;
                last = c;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (exp_q.size() != 0) $display("FAIL contention_drained got pending=%0d exp=0", exp_q.size()); else passed++;
        total++; if (last - first != 5) $display("FAIL contention_throughput got span=%0d exp=5", last - first); else passed++;
        exp_q.delete();
    endtask

    task automatic test_zero_reg();
        req1_address = 5'd31; req1_data = 64'hFFFF; req1_valid = 1'b1;
        total++; if (req1_ready !== 1'b1) $display("FAIL zero_ready_in got=%b exp=1", req1_ready); else passed++;
        tick();
        req1_valid = 1'b0;
        total++; if (rf_write !== 1'b0) $display("FAIL zero_early got=%b exp=0", rf_write); else passed++;
        total++; if (idle !== 1'b0) $display("FAIL zero_slot_full idle got=%b exp=0", idle); else passed++;
        tick();
        total++; if (rf_write !== 1'b0) $display("FAIL zero_no_write got=%b exp=0", rf_write); else passed++;
        total++; if (req1_ready !== 1'b1) $display("FAIL zero_ready_after got=%b exp=1", req1_ready); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL zero_drained idle got=%b exp=1", idle); else passed++;
        total++; if (rf_address !== 5'd31 || rf_data !== 64'hFFFF) $display("FAIL zero_out_reg got addr=%0d data=%h exp addr=31 data=ffff", rf_address, rf_data); else passed++;
        tick();
        total++; if (rf_write !== 1'b0) $display("FAIL zero_quiet got=%b exp=0", rf_write); else passed++;
    endtask

    task automatic test_reset_mid();
        wr_t  e;
        logic any_write = 1'b0;
        req0_valid = 1'b1; req0_address = 5'd4;  req0_data = 64'h44;
        req1_valid = 1'b1; req1_address = 5'd14; req1_data = 64'h1414;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
        total++; if (idle !== 1'b0) $display("FAIL mid_slots_full idle got=%b exp=0", idle); else passed++;
        tick();
        reset = 1'b1;
        total++; if (rf_write !== 1'b0) $display("FAIL mid_write_after_reset got=%b exp=0", rf_write); else passed++;
        total++; if (idle !== 1'b1) $display("FAIL mid_idle got=%b exp=1", idle); else passed++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (rf_write !== 1'b0) any_write = 1'b1;
        end
        total++; if (any_write !== 1'b0) $display("FAIL mid_discard got write=%b exp=0", any_write); else passed++;
        exp_q.push_back({5'd6, 64'h66});
        exp_q.push_back({5'd16, 64'h1616});
        req0_valid = 1'b1; req0_address = 5'd6;  req0_data = 64'h66;
        req1_valid = 1'b1; req1_address = 5'd16; req1_data = 64'h1616;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (rf_write !== 1'b1 || exp_q.size() == 0) $display("FAIL mid_tie_write%0d rf_write got=%b exp=1", k, rf_write);
            else begin
                e = exp_q.pop_front();
                if ({rf_address, rf_data} !== e) $display("FAIL mid_tie_order%0d got addr=%0d exp addr=%0d", k, rf_address, e.a);
                else passed++;
            end
        end
        exp_q.delete();
        tick();
    endtask

`ifdef REGFILE_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b1;
        total++; if (grant_count0 !== 16'd0 || grant_count1 !== 16'd0) $display("FAIL stats_reset got c0=%h c1=%h exp 0/0", grant_count0, grant_count1); else passed++;
        req0_valid = 1'b1; req0_address = 5'd2; req0_data = 64'h2;
        for (int c = 0; c < 70000; c++) tick();
        req0_valid = 1'b0;
        tick();
        tick();
        total++; if (grant_count0 !== 16'hFFFF) $display("FAIL stats_sat0 got=%h exp=ffff", grant_count0); else passed++;
        total++; if (grant_count1 !== 16'h0) $display("FAIL stats_count1 got=%h exp=0", grant_count1); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_reg();
        test_reset_mid();
`ifdef REGFILE_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
